pipeline_ctrl_unit: RTL

Centralised pipeline control for the next-generation 5-stage RV32I core. It merges load-use hazard detection, N-source operand forwarding and misprediction flush into one block. It adds what the current core lacks: variable-latency instruction/data memory handshakes with a wait-state FSM and a timeout error. It sits beside the stage registers and drives their stall/bubble/flush inputs and the EX-stage forwarding muxes.

---
 rtl/pipe_ctrl_pkg.sv | 12 +
 rtl/pipeline_ctrl_unit_fwd_select.sv | 26 ++
 rtl/pipeline_ctrl_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    ERR   = 2'd2
  } ctrl_state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pipeline_ctrl_unit_fwd_select.sv
// Forwarding priority matcher: picks the nearest writing stage whose rd matches src.
module fwd_select
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic [REG_ADDR_W-1:0]            src,
  input  logic [FWD_STAGES*REG_ADDR_W-1:0] fwd_rd,
  input  logic [FWD_STAGES-1:0]            fwd_we,
  output logic [SEL_W-1:0]                 sel
);

  always_comb begin
    sel = '0;
    if (src != '0) begin
      // Walk oldest to nearest so the lowest matching stage wins.
      for (int unsigned k = FWD_STAGES; k >= 1; k--) begin
        if (fwd_we[k-1] && (fwd_rd[(k-1)*REG_ADDR_W +: REG_ADDR_W] == src))
          sel = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Pipeline hazard, forwarding, flush and memory wait-state control for the 5-stage core.
// Optional perf counters enabled by defining PIPE_PERF_CNT_EN.
module pipeline_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned FWD_STAGES   = 2,
  parameter int unsigned SEL_W        = $clog2(FWD_STAGES + 1),
  parameter int unsigned MAX_MEM_WAIT = 15
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [REG_ADDR_W-1:0]           id_rs1,
  input  logic [REG_ADDR_W-1:0]           id_rs2,
  input  logic                            id_use_rs1,
  input  logic                            id_use_rs2,
  input  logic [REG_ADDR_W-1:0]           ex_rd,
  input  logic                            ex_we,
  input  logic                            ex_is_load,
  input  logic [REG_ADDR_W-1:0]           ex_rs1,
  input  logic [REG_ADDR_W-1:0]           ex_rs2,
  input  logic [FWD_STAGES*REG_ADDR_W-1:0] fwd_rd,
  input  logic [FWD_STAGES-1:0]           fwd_we,
  input  logic                            misprediction,
  input  logic                            imem_ready,
  input  logic                            dmem_req,
  input  logic                            dmem_ready,
  output logic                            stall_if,
  output logic                            stall_id,
  output logic                            bubble_if_id,
  output logic                            bubble_id_ex,
  output logic                            flush_if_id,
  output logic                            flush_id_ex,
  output logic                            hold_ex_mem,
  output logic                            bubble_mem_wb,
  output logic [SEL_W-1:0]                fwd_a_sel,
  output logic [SEL_W-1:0]                fwd_b_sel,
  output logic                            timeout_err,
  output logic [31:0]                     perf_load_stall,
  output logic [31:0]                     perf_dmem_wait,
  output logic [31:0]                     perf_flush,
  output logic [31:0]                     perf_imem_stall
);

  ctrl_state_e       state, state_nxt;
  logic [7:0]        wcnt, wcnt_nxt;
  logic              lu_prev;
  logic              hold_raw, lu_cond;
  logic              act_hold, act_flush, act_lu, act_imem;
  logic [SEL_W-1:0]  sel_a, sel_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      wcnt        <= '0;
      timeout_err <= 1'b0;
      lu_prev     <= 1'b0;
    end else begin
      state   <= state_nxt;
      wcnt    <= wcnt_nxt;
      lu_prev <= act_lu;
      if (state_nxt == ERR)
        timeout_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    unique case (state)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          state_nxt = DWAIT;
          wcnt_nxt  = 8'd1;
        end
      end
      DWAIT: begin
        if (dmem_ready) begin
          state_nxt = RUN;
          wcnt_nxt  = '0;
        end else if (wcnt == 8'(MAX_MEM_WAIT)) begin
          state_nxt = ERR;
        end else begin
          wcnt_nxt = wcnt + 8'd1;
        end
      end
      ERR: ;
      default: begin
        state_nxt = RUN;
        wcnt_nxt  = '0;
      end
    endcase
  end

  // Load-use answers once per occurrence; lu_prev masks the cycle right after a stall.
  always_comb begin
    hold_raw = (state != RUN) || (dmem_req && !dmem_ready);
    lu_cond  = ex_is_load && ex_we && (ex_rd != '0) &&
               ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));
    act_hold  = 1'b0;
    act_flush = 1'b0;
    act_lu    = 1'b0;
    act_imem  = 1'b0;
    if (!reset) begin
      if (hold_raw)                 act_hold  = 1'b1;
      else if (misprediction)       act_flush = 1'b1;
      else if (lu_cond && !lu_prev) act_lu    = 1'b1;
      else if (!imem_ready)         act_imem  = 1'b1;
    end
  end

  assign stall_if      = act_hold | act_lu | act_imem;
  assign stall_id      = act_hold | act_lu;
  assign hold_ex_mem   = act_hold;
  assign bubble_mem_wb = act_hold;
  assign bubble_id_ex  = act_lu;
  assign bubble_if_id  = act_imem;
  assign flush_if_id   = act_flush;
  assign flush_id_ex   = act_flush;

  fwd_select #(
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_STAGES (FWD_STAGES),
    .SEL_W      (SEL_W)
  ) u_fwd_a (
    .src    (ex_rs1),
    .fwd_rd (fwd_rd),
    .fwd_we (fwd_we),
    .sel    (sel_a)
  );

  fwd_select #(
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_STAGES (FWD_STAGES),
    .SEL_W      (SEL_W)
  ) u_fwd_b (
    .src    (ex_rs2),
    .fwd_rd (fwd_rd),
    .fwd_we (fwd_we),
    .sel    (sel_b)
  );

  assign fwd_a_sel = reset ? '0 : sel_a;
  assign fwd_b_sel = reset ? '0 : sel_b;

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_load_stall <= '0;
      perf_dmem_wait  <= '0;
      perf_flush      <= '0;
      perf_imem_stall <= '0;
    end else begin
      if (act_lu   && (perf_load_stall != '1)) perf_load_stall <= perf_load_stall + 32'd1;
      if (act_hold && (perf_dmem_wait  != '1)) perf_dmem_wait  <= perf_dmem_wait  + 32'd1;
      if (act_flush && (perf_flush     != '1)) perf_flush      <= perf_flush      + 32'd1;
      if (act_imem && (perf_imem_stall != '1)) perf_imem_stall <= perf_imem_stall + 32'd1;
    end
  end
`else
  assign perf_load_stall = '0;
  assign perf_dmem_wait  = '0;
  assign perf_flush      = '0;
  assign perf_imem_stall = '0;
`endif

endmodule
